ex_div_unit: RTL and testbench



---
 rtl/ex_div_unit.sv | 103 ++++++++++
 tb/tb_ex_div_unit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               divide request, held high by EX until ready is seen
//   signed_div          1 = DIV (two's complement), 0 = DIVU
//   annul               abort request (flush/exception), wins over start
//   opdata1, opdata2    dividend and divisor, sampled on the accepting edge
//   result              {remainder, quotient}, valid while ready is high
//   ready               result valid
//   stall_req           pipeline freeze request while a division is pending
module ex_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic               annul,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_req
);
    typedef enum logic [1:0] {S_FREE, S_DIVZERO, S_ON, S_END} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
    logic               qneg_q, rneg_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_d, quo_d, abs1, abs2, q_fix, r_fix;

    // Shifted partial remainder can reach WIDTH+1 bits, so the trial subtract is
    // one bit wider; its top bit is the borrow (negative result -> restore).
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        abs1  = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
        abs2  = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
        q_fix = qneg_q ? -quo_q : quo_q;
        r_fix = rneg_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FREE: if (start && !annul) begin
                    cnt_q   <= '0;
                    rem_q   <= '0;
                    dvs_q   <= abs2;
                    qneg_q  <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    rneg_q  <= signed_div & opdata1[WIDTH-1];
                    // divide-by-zero reports the raw dividend as remainder
                    quo_q   <= (opdata2 == '0) ? opdata1 : abs1;
                    state_q <= (opdata2 == '0) ? S_DIVZERO : S_ON;
                end
                S_DIVZERO: if (annul) begin
                    state_q <= S_FREE;
                end else begin
                    result_q <= {quo_q, {WIDTH{1'b1}}};
                    ready_q  <= 1'b1;
                    state_q  <= S_END;
                end
                S_ON: if (annul) begin
                    state_q <= S_FREE;
                end else if (cnt_q == CNT_W'(WIDTH)) begin
                    result_q <= {r_fix, q_fix};
                    ready_q  <= 1'b1;
                    state_q  <= S_END;
                end else begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_END: if (annul || !start) begin
                    result_q <= '0;
                    ready_q  <= 1'b0;
                    state_q  <= S_FREE;
                end
            endcase
        end
    end

    assign result    = result_q;
    assign ready     = ready_q;
    assign stall_req = start && !annul && (state_q != S_END);
endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: scoreboard bench for ex_div_unit (latency, results, hold/annul/reset behaviour).
module tb_ex_div_unit;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, signed_div = 1'b0, annul = 1'b0;
    logic [31:0] opdata1 = '0, opdata2 = '0;
    logic [63:0] result;
    logic        ready, stall_req;
    logic [63:0] sb[$];
    int          n_checks = 0, n_errors = 0;

    ex_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
        .opdata1(opdata1), .opdata2(opdata2), .result(result), .ready(ready),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit sd, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua, ub, q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        ua = (sd && a[31]) ? -a : a;
        ub = (sd && b[31]) ? -b : b;
        q  = ua / ub;
        r  = ua % ub;
        if (sd && (a[31] ^ b[31])) q = -q;
        if (sd && a[31]) r = -r;
        return {r, q};
    endfunction

    // Called #1 after a posedge; returns #1 after the edge on which ready is seen.
    task automatic do_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int hold, input bit annul_end);
        int n = 0, stalls = 0;
        logic [63:0] want;
        signed_div = sd; opdata1 = a; opdata2 = b; start = 1'b1;
        sb.push_back(exp);
        #1 stalls += int'(stall_req);
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
            opdata1 = $urandom; opdata2 = $urandom; signed_div = ~sd;
            if (!ready) stalls += int'(stall_req);
        end
        want = sb.pop_front();
        if (!ready) begin
            check("ready_timeout", 64'(n), 64'((b == 0) ? 2 : 34));
            start = 1'b0;
            return;
        end
        check("latency", 64'(n), 64'((b == 0) ? 2 : 34));
        check("stall_cycles", 64'(stalls), 64'((b == 0) ? 2 : 34));
        check("result", result, want);
        check("stall_at_ready", 64'(stall_req), 64'(0));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_result", result, want);
            check("hold_ready_stall", {62'(0), ready, stall_req}, 64'b10);
        end
        if (annul_end) annul = 1'b1; else start = 1'b0;
        @(posedge clk); #1;
        check("release", {ready, result}, 65'(0));
        start = 1'b0; annul = 1'b0;
    endtask

    initial begin
        bit saw;
        logic [31:0] a, b;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", {ready, stall_req, result}, 66'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        do_div(0, 100, 7, {32'd2, 32'd14}, 0, 0);
        do_div(1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 0);
        do_div(1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 0, 0);
        do_div(1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0, 0);
        do_div(0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 0, 0);
        do_div(0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 0, 0);
        do_div(1, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, 0, 1);
        do_div(0, 32'd55, 32'd10, {32'd5, 32'd5}, 5, 0);
        do_div(1, 32'hFFFF_FF9C, 32'd9, {32'hFFFF_FFFF, 32'hFFFF_FFF5}, 2, 1);

        // annul mid-division: no ready for the aborted request
        signed_div = 1'b0; opdata1 = 1000; opdata2 = 3; start = 1'b1;
        repeat (11) @(posedge clk);
        #1 annul = 1'b1;
        #1 check("stall_under_annul", 64'(stall_req), 64'(0));
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            saw |= ready;
        end
        check("annul_no_ready", 64'(saw), 64'(0));
        do_div(0, 9, 3, {32'd0, 32'd3}, 0, 0);

        // reset in the middle of a division
        signed_div = 1'b0; opdata1 = 12345; opdata2 = 7; start = 1'b1;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check("reset_mid_on", {ready, stall_req, result}, 66'(0));
        rst = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            saw |= ready;
        end
        check("reset_no_ready", 64'(saw), 64'(0));
        do_div(0, 12345, 7, {32'd4, 32'd1763}, 0, 0);

        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i == 3) ? 32'd0 : ((i % 2) ? $urandom : $urandom_range(1, 1000));
            do_div(i[0] ^ i[2], a, b, model(i[0] ^ i[2], a, b), i % 3, i[1]);
        end

        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
